scope_readout: RTL and testbench

SCOPE_READOUT -- requirements
Module: scope_readout

---
 rtl/scope_pkg.sv | 17 +
 rtl/scope_readout_serializer.sv | 46 ++++
 rtl/scope_readout.sv | 201 ++++++++++++++++++++
 tb/tb_scope_readout.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope readout block.
package scope_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      READ_ADDR,
      READ_WAIT,
      SEND,
      RELEASE
   } state_t;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
   localparam int         READ_LAT       = 2;
   localparam int         BYTES_PER_WORD = 3;

endpackage

// File: rtl/scope_readout_serializer.sv
// Emits up to three bytes of a word, MSB first, on a valid/ready byte stream.
module scope_readout_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load,
   input  logic [23:0] word,
   input  logic [1:0]  nbytes,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        empty
);

   logic [15:0] rest;
   logic [1:0]  left;

   assign empty = !tx_valid;

   // clear wins over load so a cancelled frame never starts another byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         rest     <= 16'h0000;
         left     <= 2'd0;
      end else if (clear) begin
         tx_valid <= 1'b0;
         left     <= 2'd0;
      end else if (load && !tx_valid) begin
         tx_data  <= word[23:16];
         rest     <= word[15:0];
         left     <= nbytes - 2'd1;
         tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
         if (left != 2'd0) begin
            tx_data <= rest[15:8];
            rest    <= {rest[7:0], 8'h00};
            left    <= left - 2'd1;
         end else begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/scope_readout.sv
// Captures both scope channels and streams them as a byte frame.
// Optional XOR trailer byte enabled by SCOPE_READOUT_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for a Start rising edge
// ARM       | Sample high, waiting for a fresh BufferReady rise
// READ_ADDR | address presented to the scope buffer
// READ_WAIT | read latency count-down, capture at terminal count
// SEND      | hand word (or trailer) to the serializer
// RELEASE   | Sample low for one cycle, then back to IDLE
module scope_readout
   import scope_pkg::*;
#(
   parameter int         N_SAMPLES = 2048,
   parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic        ForceReq,
   input  logic        Abort,
   input  logic [2:0]  Average,
   output logic        Sample,
   output logic        Force,
   input  logic        BufferReady,
   output logic [11:0] BufferAddress,
   input  logic [31:0] BufferData,
   output logic [7:0]  TxData,
   output logic        TxValid,
   input  logic        TxReady,
   output logic        Busy,
   output logic        Done
);

   localparam int               IDX_W    = $clog2(N_SAMPLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

   state_t      state;
   logic        start_d;
   logic        armed;
   logic        fin;
   logic [7:0]  csum;
   logic [31:0] word_q;
   logic [23:0] shifted;
   logic [1:0]  wait_cnt;
   logic        ser_load;
   logic [23:0] ser_word;
   logic [1:0]  ser_nbytes;
   logic        ser_empty;
   logic        abort_now;
   logic        last_word;
`ifdef SCOPE_READOUT_CHECKSUM_EN
   logic        trl;
`endif

   assign shifted   = 24'($signed(word_q) >>> Average);
   assign abort_now = Abort && (state != IDLE) && (state != RELEASE);
   assign last_word = BufferAddress[11] && (BufferAddress[IDX_W-1:0] == IDX_LAST);

   always_comb begin
      ser_load   = 1'b0;
      ser_word   = shifted;
      ser_nbytes = 2'(BYTES_PER_WORD);
      case (state)
         ARM: begin
            if (BufferReady && armed) begin
               ser_load   = 1'b1;
               ser_word   = {HEADER, 16'h0000};
               ser_nbytes = 2'd1;
            end
         end
         SEND: begin
            if (ser_empty) begin
               if (!fin) begin
                  ser_load = 1'b1;
               end
`ifdef SCOPE_READOUT_CHECKSUM_EN
               else if (!trl) begin
                  ser_load   = 1'b1;
                  ser_word   = {csum, 16'h0000};
                  ser_nbytes = 2'd1;
               end
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         Sample        <= 1'b0;
         Force         <= 1'b0;
         BufferAddress <= 12'h000;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         start_d       <= 1'b1;
         armed         <= 1'b0;
         fin           <= 1'b0;
         csum          <= 8'h00;
         word_q        <= 32'h0;
         wait_cnt      <= 2'd0;
`ifdef SCOPE_READOUT_CHECKSUM_EN
         trl           <= 1'b0;
`endif
      end else begin
         start_d <= Start;
         Done    <= 1'b0;
         if (abort_now) begin
            state  <= RELEASE;
            Sample <= 1'b0;
            Force  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (Start && !start_d) begin
                     state  <= ARM;
                     Sample <= 1'b1;
                     Force  <= ForceReq;
                     Busy   <= 1'b1;
                     armed  <= 1'b0;
                  end
               end
               // a BufferReady already high on entry belongs to an old capture
               ARM: begin
                  if (!BufferReady) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state         <= READ_ADDR;
                     Force         <= 1'b0;
                     BufferAddress <= 12'h000;
                     csum          <= 8'h00;
                     fin           <= 1'b0;
`ifdef SCOPE_READOUT_CHECKSUM_EN
                     trl           <= 1'b0;
`endif
                  end
               end
               READ_ADDR: begin
                  wait_cnt <= 2'(READ_LAT - 1);
                  state    <= READ_WAIT;
               end
               READ_WAIT: begin
                  if (wait_cnt == 2'd0) begin
                     word_q <= BufferData;
                     state  <= SEND;
                  end else begin
                     wait_cnt <= wait_cnt - 2'd1;
                  end
               end
               SEND: begin
                  if (ser_empty) begin
                     if (!fin) begin
                        csum <= csum ^ shifted[23:16] ^ shifted[15:8] ^ shifted[7:0];
                        if (last_word) begin
                           fin <= 1'b1;
                        end else begin
                           state <= READ_ADDR;
                           if (BufferAddress[IDX_W-1:0] == IDX_LAST)
                              BufferAddress <= 12'h800;
                           else
                              BufferAddress <= BufferAddress + 12'd1;
                        end
                     end
`ifdef SCOPE_READOUT_CHECKSUM_EN
                     else if (!trl) begin
                        trl <= 1'b1;
                     end
`endif
                     else begin
                        state  <= RELEASE;
                        Sample <= 1'b0;
                        Done   <= 1'b1;
                     end
                  end
               end
               RELEASE: begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   scope_readout_serializer u_ser (
      .clk      (Clk),
      .rst      (Reset),
      .clear    (abort_now),
      .load     (ser_load),
      .word     (ser_word),
      .nbytes   (ser_nbytes),
      .tx_ready (TxReady),
      .tx_data  (TxData),
      .tx_valid (TxValid),
      .empty    (ser_empty)
   );

endmodule

// File: tb/tb_scope_readout.sv
// Scoreboard bench for scope_readout: scope buffer model, byte monitor, directed frames.
module tb_scope_readout;

   localparam int N = 2048;
`ifdef SCOPE_READOUT_CHECKSUM_EN
   localparam int TRL = 1;
`else
   localparam int TRL = 0;
`endif
   localparam int FRAME_LEN = 1 + 6 * N + TRL;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic        ForceReq;
   logic        Abort;
   logic [2:0]  Average;
   logic        Sample;
   logic        Force;
   logic        BufferReady;
   logic [11:0] BufferAddress;
   logic [31:0] BufferData;
   logic [7:0]  TxData;
   logic        TxValid;
   logic        TxReady;
   logic        Busy;
   logic        Done;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          rx_cnt   = 0;
   int          done_cnt = 0;
   int          pat      = 0;
   bit          rdy_mode = 1'b0;
   logic [3:0]  rdy_pat  = 4'b1001;
   logic [7:0]  exp_q[$];
   logic [31:0] d1;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data  = 8'h00;

   scope_readout #(.N_SAMPLES(N), .HEADER(8'hA5)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Start         (Start),
      .ForceReq      (ForceReq),
      .Abort         (Abort),
      .Average       (Average),
      .Sample        (Sample),
      .Force         (Force),
      .BufferReady   (BufferReady),
      .BufferAddress (BufferAddress),
      .BufferData    (BufferData),
      .TxData        (TxData),
      .TxValid       (TxValid),
      .TxReady       (TxReady),
      .Busy          (Busy),
      .Done          (Done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] scope_word(input logic [11:0] a, input int p);
      case (p)
         0:       return {a, 4'h5, ~a[7:0], a[7:0]};
         1:       return 32'h0000_0100;
         default: return 32'hFFFF_FF00;
      endcase
   endfunction

   // scope buffer with two cycles of read latency
   always @(posedge Clk) begin
      d1         <= scope_word(BufferAddress, pat);
      BufferData <= d1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge Clk) begin
      if (Reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 32'(TxValid), 32'd1);
            chk("stall_data_held", 32'(TxData), 32'(prev_data));
         end
         if (TxValid && TxReady) begin
            rx_cnt++;
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("byte_value", 32'(TxData), 32'(exp_q.pop_front()));
         end
         prev_stall = TxValid && !TxReady && !Abort;
         prev_data  = TxData;
         if (Done) done_cnt++;
      end
   end

   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (rdy_mode) TxReady = rdy_pat[(n_checks + rx_cnt) % 4 == 0 ? 0 : 0];
      end
   end

   int ph = 0;
   initial begin
      forever begin
         @(posedge Clk);
         #2;
         if (rdy_mode) begin
            TxReady = rdy_pat[ph];
            ph = (ph + 1) % 4;
         end
      end
   end

   // kind 0: ramp, no shift; kind 1: 00 00 20; kind 2: FF FF C0
   task automatic push_frame(input int kind);
      logic [7:0]  x = 8'h00;
      logic [31:0] w;
      logic [7:0]  b[3];
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int ch = 0; ch < 2; ch++) begin
         for (int idx = 0; idx < N; idx++) begin
            w = scope_word(12'(ch * 2048 + idx), 0);
            case (kind)
               0: begin b[0] = w[23:16]; b[1] = w[15:8]; b[2] = w[7:0]; end
               1: begin b[0] = 8'h00; b[1] = 8'h00; b[2] = 8'h20; end
               default: begin b[0] = 8'hFF; b[1] = 8'hFF; b[2] = 8'hC0; end
            endcase
            for (int k = 0; k < 3; k++) begin
               exp_q.push_back(b[k]);
               x = x ^ b[k];
            end
         end
      end
      if (TRL != 0) exp_q.push_back(x);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic run_frame(input string tag, input int budget, input bit poke);
      int rel = 0;
      bit saw = 1'b0;
      bit fin = 1'b0;
      for (int i = 0; i < budget && !fin; i++) begin
         @(posedge Clk);
         #1;
         if (poke && i == 300) begin Start = 1'b1; ForceReq = 1'b1; end
         if (poke && i == 303) begin Start = 1'b0; ForceReq = 1'b0; end
         if (poke && i == 305) chk({tag, "_force_ignored"}, 32'(Force), 32'd0);
         if (Sample) saw = 1'b1;
         if (Busy && !Sample && saw) rel++;
         if (!Busy && saw) fin = 1'b1;
      end
      chk({tag, "_completed"}, 32'(fin), 32'd1);
      chk({tag, "_release_cycles"}, 32'(rel), 32'd1);
      chk({tag, "_byte_count"}, 32'(rx_cnt), 32'(FRAME_LEN));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; ForceReq = 1'b0; Abort = 1'b0;
      Average = 3'd0; BufferReady = 1'b0; TxReady = 1'b1;
      #23;
      chk("rst_sample", 32'(Sample), 32'd0);
      chk("rst_force", 32'(Force), 32'd0);
      chk("rst_addr", 32'(BufferAddress), 32'd0);
      chk("rst_txdata", 32'(TxData), 32'd0);
      chk("rst_txvalid", 32'(TxValid), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      cycles(3);

      // frame 1: ramp data, no averaging, TxReady always high
      pat = 0; Average = 3'd0; push_frame(0); rx_cnt = 0; done_cnt = 0;
      Start = 1'b1;
      cycles(2);
      Start = 1'b0;
      chk("f1_busy_arm", 32'(Busy), 32'd1);
      chk("f1_sample_arm", 32'(Sample), 32'd1);
      chk("f1_force_arm", 32'(Force), 32'd0);
      cycles(100);
      chk("f1_no_tx_before_ready", 32'(TxValid), 32'd0);
      BufferReady = 1'b1;
      run_frame("f1", 40000, 1'b1);
      chk("f1_sample_idle", 32'(Sample), 32'd0);
      BufferReady = 1'b0;
      cycles(5);

      // frame 2: constant 0x100 >>> 3, forced trigger, abort after 500 bytes
      pat = 1; Average = 3'd3; push_frame(1); rx_cnt = 0; done_cnt = 0;
      Start = 1'b1; ForceReq = 1'b1;
      cycles(1);
      Start = 1'b0; ForceReq = 1'b0;
      cycles(2);
      chk("f2_force_latched", 32'(Force), 32'd1);
      BufferReady = 1'b1;
      cycles(3);
      chk("f2_force_cleared", 32'(Force), 32'd0);
      for (int i = 0; i < 10000 && rx_cnt < 500; i++) cycles(1);
      chk("f2_reached_500", 32'(rx_cnt), 32'd500);
      Abort = 1'b1; TxReady = 1'b0;
      cycles(1);
      chk("f2_abort_txvalid", 32'(TxValid), 32'd0);
      chk("f2_abort_sample", 32'(Sample), 32'd0);
      chk("f2_abort_busy_release", 32'(Busy), 32'd1);
      Abort = 1'b0; TxReady = 1'b1;
      cycles(1);
      chk("f2_abort_idle", 32'(Busy), 32'd0);
      cycles(10);
      chk("f2_abort_no_done", 32'(done_cnt), 32'd0);
      chk("f2_abort_no_more_bytes", 32'(rx_cnt), 32'd500);
      exp_q.delete();
      BufferReady = 1'b0;
      cycles(3);

      // reset in the middle of a frame
      push_frame(1); rx_cnt = 0;
      Start = 1'b1;
      cycles(1);
      Start = 1'b0;
      cycles(3);
      BufferReady = 1'b1;
      cycles(50);
      chk("rst_mid_was_sending", 32'(rx_cnt > 0), 32'd1);
      #3;
      Reset = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(Busy), 32'd0);
      chk("rst_mid_txvalid", 32'(TxValid), 32'd0);
      chk("rst_mid_sample", 32'(Sample), 32'd0);
      chk("rst_mid_addr", 32'(BufferAddress), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      exp_q.delete();
      cycles(3);

      // frame 3: FFFFFF00 >>> 2, stale BufferReady at entry, TxReady 1,0,0,1
      pat = 2; Average = 3'd2; push_frame(2); rx_cnt = 0; done_cnt = 0;
      BufferReady = 1'b1;
      Start = 1'b1;
      cycles(1);
      Start = 1'b0;
      cycles(20);
      chk("f3_stale_ready_waits", 32'(TxValid), 32'd0);
      chk("f3_stale_ready_busy", 32'(Busy), 32'd1);
      BufferReady = 1'b0;
      cycles(2);
      BufferReady = 1'b1;
      rdy_mode = 1'b1;
      run_frame("f3", 60000, 1'b0);
      rdy_mode = 1'b0;
      TxReady = 1'b1;
      cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
